// File: rtl/sr04_echo_emulator.sv
// sr04_echo_emulator: HC-SR04 responder that qualifies a trigger pulse and answers with a distance-encoded echo.
module sr04_echo_emulator #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_trigger,
    input  logic [8:0] i_distance,
    input  logic       i_no_target,
    output logic       o_echo,
    output logic       o_busy,
    output logic       o_trig_err
);
    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [7:0]  TRIG_MIN   = 8'(TRIG_MIN_US);
    localparam logic [8:0]  MIN_D      = 9'(MIN_CM);
    localparam logic [8:0]  MAX_D      = 9'(MAX_CM);
    localparam logic [15:0] MUL        = 16'(US_PER_CM);
    localparam logic [15:0] TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);

    typedef enum logic [2:0] {IDLE, TRIG_MEAS, BURST, ECHO, HOLDOFF} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    sync_q;
    logic [7:0]    wcnt_q;
    logic [15:0]   cnt_q, width_q, width_d;
    logic [8:0]    dist_d;
    logic          echo_q, err_q, tick, rise, fall;

    assign tick   = div_q == DIV_LAST;
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];
    assign dist_d = i_distance < MIN_D ? MIN_D : (i_distance > MAX_D ? MAX_D : i_distance);
    assign width_d = i_no_target ? TIMEOUT : 16'(dist_d) * MUL;

    assign o_echo     = echo_q;
    assign o_trig_err = err_q;
    assign o_busy     = state_q != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            sync_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            width_q <= '0;
            echo_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_q  <= tick ? '0 : div_q + 1'b1;
            sync_q <= {sync_q[1:0], i_trigger};
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (rise) begin
                    wcnt_q  <= '0;
                    state_q <= TRIG_MEAS;
                end
                TRIG_MEAS: begin
                    if (fall) begin
                        cnt_q <= '0;
                        if (wcnt_q >= TRIG_MIN) begin
                            width_q <= width_d;
                            state_q <= BURST;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (tick && wcnt_q != 8'hFF) begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                BURST: if (tick) begin
                    if (cnt_q == BURST_LAST) begin
                        cnt_q   <= '0;
                        echo_q  <= 1'b1;
                        state_q <= ECHO;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ECHO: if (tick) begin
                    if (cnt_q == width_q - 16'd1) begin
                        cnt_q   <= '0;
                        echo_q  <= 1'b0;
                        state_q <= HOLDOFF;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HOLDOFF: if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sr04_echo_emulator.md
Name: sr04_echo_emulator

Overview:
Synthesizable responder model of an HC-SR04 ultrasonic sensor, used for on-board and in-simulation loopback of the ultrasonic ranging path.
- Watches the trigger line driven by the ranging controller.
- Qualifies the trigger pulse width, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance in cm (58 us per cm).
- Enforces a hold-off between measurements, as the real sensor does.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz; 1 us tick period = CLK_FREQ/1_000_000 clocks.
TRIG_MIN_US, 10, minimum accepted trigger high width in us.
BURST_US, 200, delay from trigger falling edge to echo rising edge, in us.
US_PER_CM, 58, echo microseconds per cm.
MIN_CM, 2, lower clamp on programmed distance.
MAX_CM, 400, upper clamp on programmed distance.
TIMEOUT_US, 38000, echo width reported when no target is present.
HOLDOFF_US, 10000, dead time after echo falls before a new trigger is accepted.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
i_trigger  input  1  trigger from the ranging controller; asynchronous, synchronized internally.
i_distance  input  9  programmed target distance in cm; sampled at trigger qualification.
i_no_target  input  1  when high at sampling, the echo reports no target (TIMEOUT_US width).
o_echo  output  1  emulated echo pulse, registered.
o_busy  output  1  high whenever state != IDLE, registered/decoded from the state register only.
o_trig_err  output  1  one-clock pulse when a trigger shorter than TRIG_MIN_US is rejected.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset state: IDLE; o_echo=0, o_busy=0, o_trig_err=0; all counters 0; synchronizer flops 0.
  - Reset asserted mid-operation drops o_echo on assertion, not on the next clock.
- Internal free-running 1 us tick: a one-clock pulse every CLK_FREQ/1e6 clocks. All us timing counts ticks, so timing tolerance is ±1 us.
- i_trigger passes through a 2-FF synchronizer, plus one further flop for edge detection. Rising and falling edges are decoded from the synchronized signal.
- State machine: IDLE, TRIG_MEAS, BURST, ECHO, HOLDOFF.
  - IDLE: on synchronized rising edge, clear the width counter and go to TRIG_MEAS.
  - TRIG_MEAS: increment the 8-bit width counter per tick, saturating at 255. On synchronized falling edge:
    - counter >= TRIG_MIN_US: latch the echo width and go to BURST.
    - otherwise: pulse o_trig_err for one clock and return to IDLE.
  - BURST: count BURST_US ticks. At the BURST_US-th tick go to ECHO; o_echo rises on the same clock edge (registered).
  - ECHO: o_echo=1; count ticks. At the tick where the count reaches the latched width, o_echo=0 and go to HOLDOFF.
  - HOLDOFF: count HOLDOFF_US ticks, then go to IDLE.
- Echo width latch, 16 bits:
  - i_no_target=1: width = TIMEOUT_US.
  - otherwise: d = clamp(i_distance, MIN_CM, MAX_CM) and width = d*US_PER_CM.
  - The multiply is unsigned, computed into 16 bits; MAX_CM*US_PER_CM = 23200 fits.
- Trigger edges in BURST, ECHO or HOLDOFF are ignored. They are neither queued nor flagged.
- A trigger still high on entry to IDLE (from HOLDOFF) is not a rising edge and is ignored until it falls and rises again.
- i_distance and i_no_target changing after the latch do not affect the pulse in flight.
- A trigger held high indefinitely keeps the block in TRIG_MEAS, with the counter saturated at 255. On release it is accepted.
- A trigger pulse shorter than one clock after synchronization may be missed entirely; this is acceptable.

Test Plan:
- Reset released, trigger high 12 us, i_distance=100 → echo rises 200±1 us after synchronized trigger fall; high 5800±1 us; o_busy high from trigger rise until 10000 us after echo fall.
- Trigger high 5 us, i_distance=100 → exactly one o_trig_err pulse of 1 clock; o_echo stays 0; block back in IDLE; a following 12 us trigger produces a normal echo.
- i_distance=450 → echo width 23200±1 us (clamp to 400). i_distance=0 → 116±1 us (clamp to 2).
- i_no_target=1, 12 us trigger → echo width 38000±1 us. Toggling i_no_target and i_distance during the echo changes nothing.
- Second 12 us trigger issued during ECHO, and again during HOLDOFF → ignored, no extra echo. Trigger 1 us after o_busy falls → accepted.
- Reset asserted 1000 us into ECHO → o_echo=0 asynchronously, o_busy=0; after release a new 12 us trigger with i_distance=50 gives 2900±1 us echo.
